// File: rtl/copperv_pkg.sv
// Shared types for the copperv memory responder: FSM states, request kinds
// and the buffered request record.
package copperv_pkg;

  // Request records are sized for the widest supported bus so that one
  // struct serves every parameterisation; unused upper bits are zero.
  localparam int MEM_ADDR_MAX_W = 64;
  localparam int MEM_DATA_MAX_W = 64;
  localparam int MEM_STRB_MAX_W = MEM_DATA_MAX_W / 8;

  // Wait-state counter width covers WAIT_STATES up to 15.
  localparam int MEM_WAIT_CNT_W = 4;

  // Slot indices inside the responder.
  localparam int MEM_SLOT_FETCH = 0;
  localparam int MEM_SLOT_DATA  = 1;
  localparam int MEM_NUM_SLOTS  = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } mem_resp_state_e;

  typedef enum logic [1:0] {
    REQ_FETCH = 2'd0,
    REQ_LOAD  = 2'd1,
    REQ_STORE = 2'd2
  } mem_req_kind_e;

  typedef struct packed {
    logic [MEM_ADDR_MAX_W-1:0] addr;
    logic [MEM_DATA_MAX_W-1:0] wdata;
    logic [MEM_STRB_MAX_W-1:0] strobe;
    mem_req_kind_e             kind;
  } mem_req_t;

  // Loads and stores both belong to the data port.
  function automatic logic is_data_kind(mem_req_kind_e kind);
    return kind != REQ_FETCH;
  endfunction

endpackage

// File: rtl/mem_req_slot.sv
// One-entry request buffer. A set while already holding a request is
// dropped and flagged through overflow_o; clear empties the entry.
module mem_req_slot
  import copperv_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     set_i,
  input  logic     clr_i,
  input  mem_req_t req_i,
  output logic     busy_o,
  output mem_req_t req_o,
  output logic     overflow_o
);

  logic     valid_q, valid_d;
  mem_req_t req_q, req_d;

  // Next entry: clear frees it, set only fills an entry that was empty.
  always_comb begin
    valid_d = valid_q;
    req_d   = req_q;
    if (clr_i) begin
      valid_d = 1'b0;
    end
    if (set_i && !valid_q) begin
      valid_d = 1'b1;
      req_d   = req_i;
    end
  end

  // Entry registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      req_q   <= '0;
    end else begin
      valid_q <= valid_d;
      req_q   <= req_d;
    end
  end

  assign busy_o     = valid_q;
  assign req_o      = req_q;
  assign overflow_o = set_i & valid_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: buffers one fetch and one data request, serialises
// them onto a single-port synchronous SRAM and returns one-cycle responses
// with registered data. Data requests win over fetches.
module mem_responder
  import copperv_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int SRAM_AW     = 12,
  parameter int WAIT_STATES = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    inst_fetch,
  input  logic [ADDR_WIDTH-1:0]   pc,
  output logic [DATA_WIDTH-1:0]   inst,
  output logic                    inst_valid,
  input  logic                    load_data,
  input  logic                    store_data,
  input  logic [ADDR_WIDTH-1:0]   data_addr,
  input  logic [DATA_WIDTH-1:0]   data_wdata,
  input  logic [DATA_WIDTH/8-1:0] data_strobe,
  output logic [DATA_WIDTH-1:0]   data_rdata,
  output logic                    data_valid,
  output logic                    sram_en,
  output logic [DATA_WIDTH/8-1:0] sram_we,
  output logic [SRAM_AW-1:0]      sram_addr,
  output logic [DATA_WIDTH-1:0]   sram_wdata,
  input  logic [DATA_WIDTH-1:0]   sram_rdata,
  output logic                    proto_err
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam logic [MEM_WAIT_CNT_W-1:0] WAIT_LAST =
    MEM_WAIT_CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  mem_resp_state_e             state_q, state_d;
  logic [MEM_WAIT_CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  mem_req_t                    work_q, work_d;
  logic [DATA_WIDTH-1:0]       inst_q, inst_d;
  logic [DATA_WIDTH-1:0]       rdata_q, rdata_d;
  logic                        inst_valid_q, inst_valid_d;
  logic                        data_valid_q, data_valid_d;
  logic                        proto_err_q, proto_err_d;

  mem_req_t                    fetch_req, data_req;
  logic                        in_flight, fetch_inflight, data_inflight;
  logic                        data_pulse, fetch_ok, data_ok;
  logic                        launch, fetch_direct, data_direct;
  mem_req_t                    launch_req;
  logic                        access;

  logic     [MEM_NUM_SLOTS-1:0] slot_set, slot_clr, slot_busy, slot_ovf;
  mem_req_t                     slot_req_in [MEM_NUM_SLOTS];
  mem_req_t                     slot_req    [MEM_NUM_SLOTS];

  // Package the incoming pulses as request records; a simultaneous
  // load and store keeps the store.
  always_comb begin
    fetch_req        = '0;
    fetch_req.addr   = MEM_ADDR_MAX_W'(pc);
    fetch_req.kind   = REQ_FETCH;
    data_req         = '0;
    data_req.addr    = MEM_ADDR_MAX_W'(data_addr);
    data_req.wdata   = MEM_DATA_MAX_W'(data_wdata);
    data_req.strobe  = MEM_STRB_MAX_W'(data_strobe);
    data_req.kind    = store_data ? REQ_STORE : REQ_LOAD;
  end

  // A port is busy while its own request occupies the SRAM pipeline.
  assign in_flight      = (state_q != ST_IDLE);
  assign fetch_inflight = in_flight && !is_data_kind(work_q.kind);
  assign data_inflight  = in_flight && is_data_kind(work_q.kind);
  assign data_pulse     = load_data | store_data;
  assign fetch_ok       = inst_fetch & ~fetch_inflight;
  assign data_ok        = data_pulse & ~data_inflight;

  // Launch selection in IDLE: buffered data, new data, buffered fetch,
  // new fetch. A pulse launched directly never touches its slot.
  always_comb begin
    launch       = 1'b0;
    launch_req   = '0;
    fetch_direct = 1'b0;
    data_direct  = 1'b0;
    slot_clr     = '0;
    if (state_q == ST_IDLE) begin
      if (slot_busy[MEM_SLOT_DATA]) begin
        launch                  = 1'b1;
        launch_req              = slot_req[MEM_SLOT_DATA];
        slot_clr[MEM_SLOT_DATA] = 1'b1;
      end else if (data_ok) begin
        launch      = 1'b1;
        launch_req  = data_req;
        data_direct = 1'b1;
      end else if (slot_busy[MEM_SLOT_FETCH]) begin
        launch                   = 1'b1;
        launch_req               = slot_req[MEM_SLOT_FETCH];
        slot_clr[MEM_SLOT_FETCH] = 1'b1;
      end else if (fetch_ok) begin
        launch       = 1'b1;
        launch_req   = fetch_req;
        fetch_direct = 1'b1;
      end
    end
  end

  // Accepted pulses that were not launched this cycle go into their slot.
  always_comb begin
    slot_set                     = '0;
    slot_set[MEM_SLOT_FETCH]     = fetch_ok & ~fetch_direct;
    slot_set[MEM_SLOT_DATA]      = data_ok & ~data_direct;
    slot_req_in[MEM_SLOT_FETCH]  = fetch_req;
    slot_req_in[MEM_SLOT_DATA]   = data_req;
  end

  for (genvar gi = 0; gi < MEM_NUM_SLOTS; gi++) begin : g_slot
    mem_req_slot u_slot (
      .clk        (clk),
      .rst        (rst),
      .set_i      (slot_set[gi]),
      .clr_i      (slot_clr[gi]),
      .req_i      (slot_req_in[gi]),
      .busy_o     (slot_busy[gi]),
      .req_o      (slot_req[gi]),
      .overflow_o (slot_ovf[gi])
    );
  end

  // Next-state and response logic of the access FSM.
  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    work_d       = work_q;
    inst_d       = inst_q;
    rdata_d      = rdata_q;
    inst_valid_d = 1'b0;
    data_valid_d = 1'b0;
    proto_err_d  = proto_err_q
                 | (|slot_ovf)
                 | (inst_fetch & fetch_inflight)
                 | (data_pulse & data_inflight)
                 | (load_data & store_data);
    case (state_q)
      ST_IDLE: begin
        if (launch) begin
          work_d     = launch_req;
          wait_cnt_d = '0;
          state_d    = (WAIT_STATES > 0) ? ST_WAIT : ST_ACCESS;
        end
      end
      ST_WAIT: begin
        if (wait_cnt_q == WAIT_LAST) begin
          wait_cnt_d = '0;
          state_d    = ST_ACCESS;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      ST_ACCESS: begin
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (is_data_kind(work_q.kind)) begin
          data_valid_d = 1'b1;
          if (work_q.kind == REQ_LOAD) begin
            rdata_d = sram_rdata;
          end
        end else begin
          inst_valid_d = 1'b1;
          inst_d       = sram_rdata;
        end
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, working request and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      wait_cnt_q   <= '0;
      work_q       <= '0;
      inst_q       <= '0;
      rdata_q      <= '0;
      inst_valid_q <= 1'b0;
      data_valid_q <= 1'b0;
      proto_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      work_q       <= work_d;
      inst_q       <= inst_d;
      rdata_q      <= rdata_d;
      inst_valid_q <= inst_valid_d;
      data_valid_q <= data_valid_d;
      proto_err_q  <= proto_err_d;
    end
  end

  // SRAM drive is gated by reset so an access cut by reset never commits.
  assign access     = (state_q == ST_ACCESS) && !rst;
  assign sram_en    = access;
  assign sram_we    = (access && work_q.kind == REQ_STORE) ? work_q.strobe[STRB_W-1:0] : '0;
  assign sram_addr  = access ? work_q.addr[SRAM_AW+1:2] : '0;
  assign sram_wdata = access ? work_q.wdata[DATA_WIDTH-1:0] : '0;

  assign inst       = inst_q;
  assign inst_valid = inst_valid_q;
  assign data_rdata = rdata_q;
  assign data_valid = data_valid_q;
  assign proto_err  = proto_err_q;

  // Byte-offset bits, wrapped high address bits and padding of the wide
  // request record are intentionally ignored.
  logic unused_bits;
  assign unused_bits = ^{work_q.addr, work_q.wdata, work_q.strobe};

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: scoreboard of expected responses
// (data and cycle) checked whenever a valid pulse appears.
module tb_mem_responder;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int SAW = 12;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT with no wait states
  logic           inst_fetch, load_data, store_data;
  logic [AW-1:0]  pc, data_addr;
  logic [DW-1:0]  inst, data_wdata, data_rdata, sram_wdata, sram_rdata;
  logic [3:0]     data_strobe, sram_we;
  logic           inst_valid, data_valid, sram_en, proto_err;
  logic [SAW-1:0] sram_addr;

  // DUT with two wait states (fetch-only)
  logic           inst_fetch_w;
  logic [AW-1:0]  pc_w;
  logic [DW-1:0]  inst_w, data_rdata_w, sram_wdata_w, sram_rdata_w;
  logic [3:0]     sram_we_w;
  logic           inst_valid_w, data_valid_w, sram_en_w, proto_err_w;
  logic [SAW-1:0] sram_addr_w;
  logic           zero_bit = 1'b0;
  logic [AW-1:0]  zero_addr = '0;
  logic [DW-1:0]  zero_data = '0;
  logic [3:0]     zero_strb = '0;

  mem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SRAM_AW(SAW), .WAIT_STATES(0)) u_dut (
    .clk(clk), .rst(rst),
    .inst_fetch(inst_fetch), .pc(pc), .inst(inst), .inst_valid(inst_valid),
    .load_data(load_data), .store_data(store_data), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_strobe(data_strobe),
    .data_rdata(data_rdata), .data_valid(data_valid),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .proto_err(proto_err)
  );

  mem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SRAM_AW(SAW), .WAIT_STATES(2)) u_dut_ws2 (
    .clk(clk), .rst(rst),
    .inst_fetch(inst_fetch_w), .pc(pc_w), .inst(inst_w), .inst_valid(inst_valid_w),
    .load_data(zero_bit), .store_data(zero_bit), .data_addr(zero_addr),
    .data_wdata(zero_data), .data_strobe(zero_strb),
    .data_rdata(data_rdata_w), .data_valid(data_valid_w),
    .sram_en(sram_en_w), .sram_we(sram_we_w), .sram_addr(sram_addr_w),
    .sram_wdata(sram_wdata_w), .sram_rdata(sram_rdata_w), .proto_err(proto_err_w)
  );

  // Initial SRAM image
  function automatic logic [31:0] init_val(input int i);
    case (i)
      'h40:    return 32'h0000_0013;
      2:       return 32'h1122_3344;
      default: return 32'h5A00_0000 | 32'(i);
    endcase
  endfunction

  // SRAM model: registered read one cycle after en, byte-enabled write
  logic [31:0] mem [0:4095];
  logic        mem_init;
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 4096; i++) mem[i] <= init_val(i);
    end else begin
      if (sram_en) begin
        if (sram_we != 4'b0) begin
          for (int b = 0; b < 4; b++)
            if (sram_we[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
        end else begin
          sram_rdata <= mem[sram_addr];
        end
      end
      if (sram_en_w) sram_rdata_w <= mem[sram_addr_w];
    end
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t inst_exp[$];
  exp_t data_exp[$];

  task automatic push_inst(input logic [31:0] d, input int c);
    exp_t e;
    e.data = d; e.cyc = c;
    inst_exp.push_back(e);
  endtask

  task automatic push_data(input logic [31:0] d, input int c);
    exp_t e;
    e.data = d; e.cyc = c;
    data_exp.push_back(e);
  endtask

  // Scoreboard: every valid pulse must match the oldest expectation
  always @(negedge clk) begin : mon
    exp_t e;
    if (inst_valid) begin
      if (inst_exp.size() == 0) begin
        chk("inst_valid_unexpected", 64'(cyc), 64'hFFFF_FFFF);
      end else begin
        e = inst_exp.pop_front();
        $display("inst response cyc=%0d inst=0x%08h", cyc, inst);
        chk("inst_data", inst, e.data);
        chk("inst_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
    if (data_valid) begin
      if (data_exp.size() == 0) begin
        chk("data_valid_unexpected", 64'(cyc), 64'hFFFF_FFFF);
      end else begin
        e = data_exp.pop_front();
        $display("data response cyc=%0d rdata=0x%08h", cyc, data_rdata);
        chk("data_rdata", data_rdata, e.data);
        chk("data_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int          t0;
  logic [31:0] last_data;

  initial begin
    rst = 1'b1; mem_init = 1'b1;
    inst_fetch = 0; load_data = 0; store_data = 0;
    pc = '0; data_addr = '0; data_wdata = '0; data_strobe = '0;
    inst_fetch_w = 0; pc_w = '0;
    last_data = '0;
    repeat (3) tick();
    mem_init = 1'b0;

    // Reset state
    chk("reset_flags", {inst_valid, data_valid, proto_err, sram_en}, 0);
    chk("reset_inst", inst, 0);
    chk("reset_rdata", data_rdata, 0);
    chk("reset_sram_bus", {sram_we, sram_addr, sram_wdata}, 0);
    rst = 1'b0;
    tick();
    chk("idle_after_reset", {inst_valid, data_valid, proto_err, sram_en, inst_valid_w, sram_en_w}, 0);

    // Plain fetch
    t0 = cyc; inst_fetch = 1; pc = 32'h100;
    push_inst(32'h13, t0 + 3);
    tick(); inst_fetch = 0;
    chk("fetch_access_en", sram_en, 1);
    chk("fetch_access_addr", sram_addr, 12'h040);
    chk("fetch_access_we", sram_we, 0);
    repeat (5) tick();

    // Partial store, response leaves data_rdata unchanged
    t0 = cyc; store_data = 1; data_addr = 32'h8; data_wdata = 32'hAABB_CCDD; data_strobe = 4'b0011;
    push_data(last_data, t0 + 3);
    tick(); store_data = 0;
    chk("store_access_en", sram_en, 1);
    chk("store_access_addr", sram_addr, 12'h002);
    chk("store_access_we", sram_we, 4'b0011);
    chk("store_access_wdata", sram_wdata, 32'hAABB_CCDD);
    repeat (5) tick();

    // Load back: only low two bytes replaced
    t0 = cyc; load_data = 1; data_addr = 32'h8;
    last_data = 32'h1122_CCDD;
    push_data(last_data, t0 + 3);
    tick(); load_data = 0;
    chk("load_access_we", sram_we, 0);
    repeat (5) tick();

    // Simultaneous fetch and load: data first, fetch three cycles later
    t0 = cyc; inst_fetch = 1; pc = 32'h104; load_data = 1; data_addr = 32'h0;
    last_data = init_val(0);
    push_data(last_data, t0 + 3);
    push_inst(init_val('h41), t0 + 6);
    tick(); inst_fetch = 0; load_data = 0;
    repeat (8) tick();
    chk("dual_no_proto_err", proto_err, 0);

    // Second fetch while the first is outstanding
    t0 = cyc; inst_fetch = 1; pc = 32'h108;
    push_inst(init_val('h42), t0 + 3);
    tick(); pc = 32'h10C;
    chk("overlap_err_t1", proto_err, 0);
    tick(); inst_fetch = 0;
    chk("overlap_err_t2", proto_err, 1);
    repeat (8) tick();
    chk("proto_err_sticky", proto_err, 1);
    chk("queues_drained_a", 64'(inst_exp.size() + data_exp.size()), 0);

    // Reset clears the sticky flag and response data
    rst = 1'b1;
    tick(); tick();
    chk("rst_clears_err", proto_err, 0);
    chk("rst_clears_inst", inst, 0);
    chk("rst_clears_rdata", data_rdata, 0);
    rst = 1'b0; last_data = '0;
    tick();

    // Load and store in the same cycle: store wins, error flagged
    t0 = cyc; load_data = 1; store_data = 1; data_addr = 32'hC;
    data_wdata = 32'h5566_7788; data_strobe = 4'b1111;
    push_data(last_data, t0 + 3);
    tick(); load_data = 0; store_data = 0;
    chk("collision_err", proto_err, 1);
    chk("collision_keeps_store", sram_we, 4'b1111);
    repeat (5) tick();
    t0 = cyc; load_data = 1; data_addr = 32'hC;
    last_data = 32'h5566_7788;
    push_data(last_data, t0 + 3);
    tick(); load_data = 0;
    repeat (5) tick();

    // Load arriving while a fetch is in flight waits in its slot
    t0 = cyc; inst_fetch = 1; pc = 32'h100;
    push_inst(32'h13, t0 + 3);
    tick(); inst_fetch = 0; load_data = 1; data_addr = 32'h8;
    last_data = 32'h1122_CCDD;
    push_data(last_data, t0 + 6);
    tick(); load_data = 0;
    repeat (8) tick();
    chk("queues_drained_b", 64'(inst_exp.size() + data_exp.size()), 0);

    // Reset during the ACCESS cycle of a store
    store_data = 1; data_addr = 32'h10; data_wdata = 32'hDEAD_BEEF; data_strobe = 4'b1111;
    tick(); store_data = 0;
    chk("pre_reset_access_en", sram_en, 1);
    rst = 1'b1;
    #1;
    chk("reset_gates_en", sram_en, 0);
    chk("reset_gates_we", sram_we, 0);
    tick(); rst = 1'b0;
    #1;
    chk("post_reset_outputs", {inst_valid, data_valid, proto_err, sram_en, sram_we, sram_addr, sram_wdata}, 0);
    chk("post_reset_data", {inst, data_rdata}, 0);
    last_data = '0;
    repeat (5) tick();
    t0 = cyc; load_data = 1; data_addr = 32'h10;
    last_data = init_val(4);
    push_data(last_data, t0 + 3);
    tick(); load_data = 0;
    repeat (5) tick();

    // Two wait states
    inst_fetch_w = 1; pc_w = 32'h100;
    tick(); inst_fetch_w = 0;
    chk("ws2_t1_en", sram_en_w, 0);
    tick();
    chk("ws2_t2_en", sram_en_w, 0);
    tick();
    chk("ws2_t3_en", sram_en_w, 1);
    chk("ws2_t3_addr", sram_addr_w, 12'h040);
    tick();
    chk("ws2_t4_valid", inst_valid_w, 0);
    tick();
    chk("ws2_t5_valid", inst_valid_w, 1);
    chk("ws2_t5_inst", inst_w, 32'h13);
    tick();
    chk("ws2_t6_valid", inst_valid_w, 0);

    chk("queues_drained_end", 64'(inst_exp.size() + data_exp.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
